// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder between the UART RX FIFO and the stopwatch/watch control unit.
// Single letters become control pulses; "S" + six digits + CR/LF loads a validated time.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_pop,
    output logic       o_run_stop,
    output logic       o_clear,
    output logic       o_mode,
    output logic       o_set_valid,
    output logic [4:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
    output logic       o_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] CNT_FIRE = (CNT_W + 1)'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SET      = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    logic [7:0]       byte_r;
    logic             pop_r;
    state_t           state_r,  state_s;
    logic [2:0]       idx_r,    idx_s;
    logic [5:0][3:0]  digit_r,  digit_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic             run_stop_r, run_stop_s;
    logic             clear_r,    clear_s;
    logic             mode_r,     mode_s;
    logic             set_valid_r, set_valid_s;
    logic             err_r,      err_s;
    logic [4:0]       hour_r,     hour_s;
    logic [5:0]       min_r,      min_s;
    logic [5:0]       sec_r,      sec_s;
    logic [6:0]       hour_val_s, min_val_s, sec_val_s;
    logic             time_ok_s;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    assign hour_val_s = two_digit(digit_r[0], digit_r[1]);
    assign min_val_s  = two_digit(digit_r[2], digit_r[3]);
    assign sec_val_s  = two_digit(digit_r[4], digit_r[5]);
    assign time_ok_s  = (hour_val_s < 7'd24) && (min_val_s < 7'd60) && (sec_val_s < 7'd60);
    assign cnt_inc_s  = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};

    // Decode the captured byte (or the inter-byte timeout) into next state and output pulses.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        digit_s     = digit_r;
        cnt_s       = cnt_r;
        run_stop_s  = 1'b0;
        clear_s     = 1'b0;
        mode_s      = 1'b0;
        set_valid_s = 1'b0;
        err_s       = 1'b0;
        hour_s      = hour_r;
        min_s       = min_r;
        sec_s       = sec_r;
        if (pop_r) begin
            cnt_s = '0;
            case (state_r)
                ST_IDLE: begin
                    case (byte_r)
                        8'h52, 8'h72: run_stop_s = 1'b1;
                        8'h43, 8'h63: clear_s    = 1'b1;
                        8'h4D, 8'h6D: mode_s     = 1'b1;
                        8'h53, 8'h73: begin
                            state_s = ST_SET;
                            idx_s   = 3'd0;
                        end
                        8'h0D, 8'h0A, 8'h20: begin
                            state_s = ST_IDLE;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
                ST_SET: begin
                    if (is_digit(byte_r)) begin
                        digit_s[idx_r] = byte_r[3:0];
                        if (idx_r == 3'd5) begin
                            state_s = ST_WAIT_END;
                            idx_s   = 3'd0;
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end else begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                        idx_s   = 3'd0;
                    end
                end
                ST_WAIT_END: begin
                    state_s = ST_IDLE;
                    if (is_eol(byte_r) && time_ok_s) begin
                        set_valid_s = 1'b1;
                        hour_s      = hour_val_s[4:0];
                        min_s       = min_val_s[5:0];
                        sec_s       = sec_val_s[5:0];
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = 3'd0;
                end
            endcase
        end else if (state_r != ST_IDLE) begin
            // Fires as the idle count reaches TIMEOUT_CYCLES-1, so the pulse lands TIMEOUT_CYCLES after the last decode.
            if (cnt_inc_s >= CNT_FIRE) begin
                err_s   = 1'b1;
                state_s = ST_IDLE;
                idx_s   = 3'd0;
                digit_s = '0;
                cnt_s   = '0;
            end else begin
                cnt_s = cnt_inc_s[CNT_W-1:0];
            end
        end else begin
            cnt_s = '0;
        end
    end

    // Byte fetch: capture the FIFO head and pop it on alternate cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_r <= 8'h00;
            pop_r  <= 1'b0;
        end else if (!rx_empty && !pop_r) begin
            byte_r <= rx_data;
            pop_r  <= 1'b1;
        end else begin
            pop_r  <= 1'b0;
        end
    end

    // Command FSM state, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            digit_r     <= '0;
            cnt_r       <= '0;
            run_stop_r  <= 1'b0;
            clear_r     <= 1'b0;
            mode_r      <= 1'b0;
            set_valid_r <= 1'b0;
            err_r       <= 1'b0;
            hour_r      <= 5'd0;
            min_r       <= 6'd0;
            sec_r       <= 6'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            digit_r     <= digit_s;
            cnt_r       <= cnt_s;
            run_stop_r  <= run_stop_s;
            clear_r     <= clear_s;
            mode_r      <= mode_s;
            set_valid_r <= set_valid_s;
            err_r       <= err_s;
            hour_r      <= hour_s;
            min_r       <= min_s;
            sec_r       <= sec_s;
        end
    end

    assign rx_pop      = pop_r;
    assign o_run_stop  = run_stop_r;
    assign o_clear     = clear_r;
    assign o_mode      = mode_r;
    assign o_set_valid = set_valid_r;
    assign o_err       = err_r;
    assign o_set_hour  = hour_r;
    assign o_set_min   = min_r;
    assign o_set_sec   = sec_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: FIFO model, directed scenarios and a randomized command stream
// compared against a byte-level reference model of the command language.
module tb_uart_cmd_decoder;

    localparam int unsigned T = 100;
    localparam int K_RUN = 0, K_CLR = 1, K_MODE = 2, K_SET = 3, K_ERR = 4;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_pop;
    logic       o_run_stop, o_clear, o_mode, o_set_valid, o_err;
    logic [4:0] o_set_hour;
    logic [5:0] o_set_min, o_set_sec;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop),
        .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode), .o_set_valid(o_set_valid),
        .o_set_hour(o_set_hour), .o_set_min(o_set_min), .o_set_sec(o_set_sec), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int kind; int hh; int mm; int ss; int cyc; } ev_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_pop = 0;
    bit         m_in_set = 1'b0;
    int         m_dig[$];

    task automatic refresh();
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 8'h00 : fifo[0];
    endtask

    task automatic push_exp(input int kind, input int hh, input int mm, input int ss);
        ev_t e;
        e.kind = kind; e.hh = hh; e.mm = mm; e.ss = ss; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    // Reference model: idle letters map to pulses; after S, collect six digits, then expect an end of line.
    task automatic model_byte(input logic [7:0] b);
        int hh, mm, ss;
        if (!m_in_set) begin
            case (b)
                8'h52, 8'h72: push_exp(K_RUN, 0, 0, 0);
                8'h43, 8'h63: push_exp(K_CLR, 0, 0, 0);
                8'h4D, 8'h6D: push_exp(K_MODE, 0, 0, 0);
                8'h53, 8'h73: begin m_in_set = 1'b1; m_dig.delete(); end
                8'h0D, 8'h0A, 8'h20: ;
                default: push_exp(K_ERR, 0, 0, 0);
            endcase
        end else if (m_dig.size() < 6) begin
            if (b >= 8'h30 && b <= 8'h39) m_dig.push_back(int'(b) - 48);
            else begin push_exp(K_ERR, 0, 0, 0); m_in_set = 1'b0; end
        end else begin
            m_in_set = 1'b0;
            hh = m_dig[0] * 10 + m_dig[1];
            mm = m_dig[2] * 10 + m_dig[3];
            ss = m_dig[4] * 10 + m_dig[5];
            if ((b == 8'h0D || b == 8'h0A) && hh < 24 && mm < 60 && ss < 60) push_exp(K_SET, hh, mm, ss);
            else push_exp(K_ERR, 0, 0, 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
        refresh();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // One cycle: sample outputs at the falling edge, retire the popped byte, record pulses.
    task automatic tick();
        logic [4:0] p;
        ev_t e;
        @(negedge clk);
        cyc++;
        if (rx_pop === 1'b1) begin
            last_pop = cyc;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        p = {o_err, o_set_valid, o_mode, o_clear, o_run_stop};
        if (p !== 5'd0) begin
            total++;
            if ($countones(p) !== 1) begin
                bad++;
                $display("FAIL pulse_exclusive cyc=%0d got=%b want=one-hot", cyc, p);
            end
            for (int i = 0; i < 5; i++) begin
                if (p[i]) begin
                    e.kind = i; e.hh = int'(o_set_hour); e.mm = int'(o_set_min);
                    e.ss = int'(o_set_sec); e.cyc = cyc;
                    obs_q.push_back(e);
                end
            end
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((fifo.size() > 0 || rx_pop === 1'b1) && t < budget) begin
            tick();
            t++;
        end
        total++;
        if (t >= budget) begin
            bad++;
            $display("FAIL drain_timeout got=%0d cycles want<%0d", t, budget);
        end
        repeat (3) tick();
    endtask

    task automatic run_cmd(input string body, input logic [7:0] term);
        obs_q.delete();
        send_str(body);
        if (term !== 8'h00) send_byte(term);
        drain(100);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({rx_pop, o_run_stop, o_clear, o_mode, o_set_valid, o_err, o_set_hour, o_set_min, o_set_sec} !== 23'd0) begin
            bad++;
            $display("FAIL reset_hold got=%0d want=0", {o_set_hour, o_set_min, o_set_sec});
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({rx_pop, o_run_stop, o_clear, o_mode, o_set_valid, o_err, o_set_hour, o_set_min, o_set_sec} !== 23'd0) begin
                bad++;
                $display("FAIL idle_after_reset got=%b want=0", {rx_pop, o_run_stop, o_clear, o_mode, o_set_valid, o_err});
            end
        end
    endtask

    task automatic test_single();
        string cmds;
        int ek[4];
        int n;
        cmds = "rCmx";
        ek = '{K_RUN, K_CLR, K_MODE, K_ERR};
        for (int i = 0; i < 4; i++) begin
            obs_q.delete();
            send_byte(cmds[i]);
            n = cyc;
            repeat (6) tick();
            total++;
            if (obs_q.size() !== 1) begin
                bad++;
                $display("FAIL single_count[%0d] got=%0d want=1", i, obs_q.size());
            end else begin
                total++;
                if (obs_q[0].kind !== ek[i]) begin
                    bad++;
                    $display("FAIL single_kind[%0d] got=%0d want=%0d", i, obs_q[0].kind, ek[i]);
                end
                total++;
                if (obs_q[0].cyc !== n + 2) begin
                    bad++;
                    $display("FAIL single_latency[%0d] got=%0d want=%0d", i, obs_q[0].cyc, n + 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        obs_q.delete();
        send_byte(8'h52);
        send_byte(8'h43);
        n = cyc;
        drain(40);
        total++;
        if (obs_q.size() !== 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", obs_q.size());
        end else begin
            total++;
            if (obs_q[0].kind !== K_RUN || obs_q[0].cyc !== n + 2) begin
                bad++;
                $display("FAIL b2b_first got=kind%0d@%0d want=kind%0d@%0d", obs_q[0].kind, obs_q[0].cyc, K_RUN, n + 2);
            end
            total++;
            if (obs_q[1].kind !== K_CLR || obs_q[1].cyc !== n + 4) begin
                bad++;
                $display("FAIL b2b_second got=kind%0d@%0d want=kind%0d@%0d", obs_q[1].kind, obs_q[1].cyc, K_CLR, n + 4);
            end
        end
    endtask

    task automatic check_one_set(input string name, input int hh, input int mm, input int ss);
        total++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== K_SET) begin
            bad++;
            $display("FAIL %s_event got=%0d events want=1 set", name, obs_q.size());
        end else begin
            total++;
            if (obs_q[0].hh !== hh || obs_q[0].mm !== mm || obs_q[0].ss !== ss) begin
                bad++;
                $display("FAIL %s_fields got=%0d:%0d:%0d want=%0d:%0d:%0d", name,
                         obs_q[0].hh, obs_q[0].mm, obs_q[0].ss, hh, mm, ss);
            end
        end
    endtask

    task automatic check_one_err(input string name);
        total++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== K_ERR) begin
            bad++;
            $display("FAIL %s got=%0d events (first kind %0d) want=1 err", name, obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].kind : -1);
        end
    endtask

    task automatic check_fields(input string name, input int hh, input int mm, input int ss);
        total++;
        if (int'(o_set_hour) !== hh || int'(o_set_min) !== mm || int'(o_set_sec) !== ss) begin
            bad++;
            $display("FAIL %s got=%0d:%0d:%0d want=%0d:%0d:%0d", name, o_set_hour, o_set_min, o_set_sec, hh, mm, ss);
        end
    endtask

    task automatic test_valid_set();
        run_cmd("S123456", 8'h0D);
        check_one_set("set_cr", 12, 34, 56);
        check_fields("hold_cr", 12, 34, 56);
        run_cmd("s235959", 8'h0A);
        check_one_set("set_lf", 23, 59, 59);
        check_fields("hold_lf", 23, 59, 59);
    endtask

    task automatic test_errors();
        run_cmd("S240000", 8'h0D);
        check_one_err("hour_range");
        check_fields("fields_kept_hour", 23, 59, 59);
        run_cmd("S236000", 8'h0A);
        check_one_err("min_range");
        run_cmd("S235960", 8'h0D);
        check_one_err("sec_range");
        check_fields("fields_kept_sec", 23, 59, 59);
        run_cmd("S12ar", 8'h00);
        total++;
        if (obs_q.size() !== 2 || obs_q[0].kind !== K_ERR || obs_q[1].kind !== K_RUN) begin
            bad++;
            $display("FAIL bad_digit_then_r got=%0d events want=err,run", obs_q.size());
        end
        run_cmd("S123456X", 8'h00);
        check_one_err("bad_terminator");
        check_fields("fields_kept_term", 23, 59, 59);
        run_cmd("S000000", 8'h0A);
        check_one_set("set_zero", 0, 0, 0);
    endtask

    task automatic test_timeout();
        int d, n;
        obs_q.delete();
        send_str("S12");
        drain(40);
        d = last_pop;
        while (cyc < d + int'(T) + 5) tick();
        check_one_err("timeout_event");
        if (obs_q.size() == 1) begin
            total++;
            if (obs_q[0].cyc !== d + int'(T)) begin
                bad++;
                $display("FAIL timeout_latency got=%0d want=%0d", obs_q[0].cyc, d + int'(T));
            end
        end
        obs_q.delete();
        send_byte(8'h63);
        n = cyc;
        repeat (6) tick();
        total++;
        if (obs_q.size() !== 1 || obs_q[0].kind !== K_CLR || obs_q[0].cyc !== n + 2) begin
            bad++;
            $display("FAIL clear_after_timeout got=%0d events want=1 clear at %0d", obs_q.size(), n + 2);
        end
    endtask

    task automatic test_reset_mid();
        obs_q.delete();
        send_str("S123");
        drain(40);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_fields("fields_after_reset", 0, 0, 0);
        obs_q.delete();
        send_str("456");
        send_byte(8'h0D);
        drain(40);
        total++;
        if (obs_q.size() !== 3) begin
            bad++;
            $display("FAIL reset_mid_count got=%0d want=3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs_q[i].kind !== K_ERR) begin
                    bad++;
                    $display("FAIL reset_mid_kind[%0d] got=%0d want=%0d", i, obs_q[i].kind, K_ERR);
                end
            end
        end
        check_fields("fields_no_set", 0, 0, 0);
        // A byte already fetched when reset hits must not be decoded.
        obs_q.delete();
        send_byte(8'h72);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (4) tick();
        total++;
        if (obs_q.size() !== 0) begin
            bad++;
            $display("FAIL inflight_drop got=%0d events want=0", obs_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] singles[9];
        logic [7:0] b;
        int sel, hh, mm, ss, k, term, nchk;
        singles = '{8'h52, 8'h72, 8'h43, 8'h63, 8'h4D, 8'h6D, 8'h20, 8'h0D, 8'h0A};
        m_in_set = 1'b0;
        m_dig.delete();
        exp_q.delete();
        obs_q.delete();
        for (int c = 0; c < 40; c++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: send_byte(singles[$urandom_range(0, 8)]);
                1: begin
                    do b = 8'($urandom_range(0, 255)); while (b == 8'h53 || b == 8'h73);
                    send_byte(b);
                end
                2, 3: begin
                    send_byte((sel == 2) ? 8'h53 : 8'h73);
                    hh = int'($urandom_range(0, 29));
                    mm = int'($urandom_range(0, 69));
                    ss = int'($urandom_range(0, 69));
                    send_byte(8'h30 + 8'(hh / 10)); send_byte(8'h30 + 8'(hh % 10));
                    send_byte(8'h30 + 8'(mm / 10)); send_byte(8'h30 + 8'(mm % 10));
                    send_byte(8'h30 + 8'(ss / 10)); send_byte(8'h30 + 8'(ss % 10));
                    term = int'($urandom_range(0, 3));
                    send_byte((term == 0) ? 8'h58 : ((term == 1) ? 8'h0D : 8'h0A));
                end
                default: begin
                    send_byte(8'h53);
                    k = int'($urandom_range(0, 5));
                    for (int j = 0; j < k; j++) send_byte(8'h30 + 8'($urandom_range(0, 9)));
                    send_byte(8'($urandom_range(8'h3A, 8'h7E)));
                end
            endcase
            repeat ($urandom_range(0, 15)) tick();
        end
        drain(2000);
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        nchk = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nchk; i++) begin
            total++;
            if (obs_q[i].kind !== exp_q[i].kind) begin
                bad++;
                $display("FAIL rand_kind[%0d] got=%0d want=%0d", i, obs_q[i].kind, exp_q[i].kind);
            end else if (exp_q[i].kind == K_SET) begin
                total++;
                if (obs_q[i].hh !== exp_q[i].hh || obs_q[i].mm !== exp_q[i].mm || obs_q[i].ss !== exp_q[i].ss) begin
                    bad++;
                    $display("FAIL rand_fields[%0d] got=%0d:%0d:%0d want=%0d:%0d:%0d", i,
                             obs_q[i].hh, obs_q[i].mm, obs_q[i].ss, exp_q[i].hh, exp_q[i].mm, exp_q[i].ss);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_valid_set();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
